// File: rtl/lsu_arbiter.sv
// lsu_arbiter
//   Shares one single-port load/store unit between NUM_REQ requesters.
//   Grants are round-robin, and only one transaction is in flight at a time.
//   The block drives the registered LSU strobes and returns one response pulse
//   per transaction: read data for a load, or a zero-data ack for a store.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   req_valid    in   [NUM_REQ]         request pending per requester
//   req_write    in   [NUM_REQ]         1 = store, 0 = load
//   req_addr     in   [NUM_REQ*ADDR_W]  requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata    in   [NUM_REQ*DATA_W]  requester i at [i*DATA_W +: DATA_W]
//   req_ready    out  [NUM_REQ]         one-hot grant, asserted only in IDLE
//   resp_valid   out  [NUM_REQ]         one-hot single-cycle response pulse
//   resp_rdata   out  [DATA_W]          load data; 0 on store acks and when idle
//   mem_read     out  LSU read strobe (registered)
//   mem_write    out  LSU write strobe (registered)
//   mem_addr     out  [ADDR_W]          LSU address (registered)
//   mem_wdata    out  [DATA_W]          LSU write data (registered)
//   mem_rdata    in   [DATA_W]          LSU read data, LATENCY cycles after strobe
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrate; grant the first valid requester from rr_ptr onward
// ISSUE | mem_read/mem_write asserted for exactly one cycle
// WAIT  | count LSU latency; capture read data on the LATENCY-th cycle
// RESP  | pulse resp_valid to the owner; advance rr_ptr past the owner
module lsu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDX_W = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   idx_q;
  logic               write_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               mem_read_q, mem_write_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;

  logic               found;
  logic [IDX_W-1:0]   win_idx;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               lat_done;
  logic [IDX_W-1:0]   rr_next;

  assign lat_done = (cnt_q == CNT_W'(LATENCY));
  // The owner gets lowest priority in the next round.
  assign rr_next  = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  // Round-robin scan starting at rr_ptr_q; the first valid requester wins.
  always_comb begin : p_arb
    int cand;
    cand      = 0;
    found     = 1'b0;
    win_idx   = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        win_idx   = IDX_W'(cand);
        sel_write = req_write[cand];
        sel_addr  = req_addr[cand*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[cand*DATA_W +: DATA_W];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (lat_done) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; grant and response live in disjoint states, so they can
  // never overlap.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i]  = (state_q == S_IDLE) && found && (win_idx == IDX_W'(i));
      resp_valid[i] = (state_q == S_RESP) && (idx_q == IDX_W'(i));
    end
    if (state_q == S_RESP) resp_rdata = rdata_q;
  end

  // Transaction datapath. Requester inputs are sampled only on the grant edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            idx_q       <= win_idx;
            write_q     <= sel_write;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_read_q  <= ~sel_write;
            mem_write_q <= sel_write;
          end
        end
        S_ISSUE: begin
          // Strobes drop; addr/wdata hold for the rest of the transaction.
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          cnt_q       <= CNT_W'(1);
        end
        S_WAIT: begin
          if (lat_done) rdata_q <= write_q ? '0 : mem_rdata;
          else          cnt_q   <= cnt_q + 1'b1;
        end
        S_RESP: begin
          rr_ptr_q <= rr_next;
        end
        default: ;
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
module tb_lsu_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int oh2i(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- DUT A: LATENCY = 1 ----------------
  logic [3:0]  rv, rw;
  logic [7:0]  ra [4];
  logic [7:0]  rdw [4];
  logic [31:0] req_addr_a, req_wdata_a;
  logic [3:0]  req_ready_a, resp_valid_a;
  logic [7:0]  resp_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        mem_read_a, mem_write_a;

  assign req_addr_a  = {ra[3], ra[2], ra[1], ra[0]};
  assign req_wdata_a = {rdw[3], rdw[2], rdw[1], rdw[0]};

  lsu_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(rv), .req_write(rw), .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .req_ready(req_ready_a), .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  logic [7:0] mem_a [256];
  always @(posedge clk) begin
    if (mem_write_a) mem_a[mem_addr_a] <= mem_wdata_a;
    if (mem_read_a)  mem_rdata_a <= mem_a[mem_addr_a];
  end

  // ---------------- DUT B: LATENCY = 3 ----------------
  logic [3:0]  rv_b;
  logic [31:0] req_addr_b;
  logic [3:0]  req_ready_b, resp_valid_b;
  logic [7:0]  resp_rdata_b, mem_addr_b, mem_wdata_b;
  logic        mem_read_b, mem_write_b;
  logic [7:0]  p0, p1, p2;

  lsu_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .LATENCY(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(rv_b), .req_write(4'b0000), .req_addr(req_addr_b), .req_wdata(32'h0),
    .req_ready(req_ready_b), .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(p2)
  );

  logic [7:0] mem_b [256];
  always @(posedge clk) begin
    if (mem_write_b) mem_b[mem_addr_b] <= mem_wdata_b;
    if (mem_read_b)  p0 <= mem_b[mem_addr_b];
    p1 <= p0;
    p2 <= p1;
  end

  // ---------------- scoreboard for DUT A ----------------
  typedef struct { int idx; int w; int a; int d; } grant_t;
  typedef struct { int idx; int rd; } resp_t;
  grant_t exp_grant[$];
  resp_t  exp_resp[$];

  grant_t cur;
  int     grant_cyc = -100;

  always @(negedge clk) begin
    if (reset) begin
      if (req_ready_a != 4'b0) begin
        check("ready_onehot", $countones(req_ready_a), 1);
        check("ready_with_resp", int'(resp_valid_a), 0);
        if (exp_grant.size() == 0) check("unexpected_grant", oh2i(req_ready_a), -1);
        else begin
          cur = exp_grant.pop_front();
          check("grant_idx", oh2i(req_ready_a), cur.idx);
          grant_cyc = cyc;
        end
      end
      if (cyc == grant_cyc + 1) begin
        check("mem_read_strobe",  int'(mem_read_a),  cur.w == 0 ? 1 : 0);
        check("mem_write_strobe", int'(mem_write_a), cur.w);
        check("mem_addr",  int'(mem_addr_a),  cur.a);
        check("mem_wdata", int'(mem_wdata_a), cur.d);
      end
      if (cyc == grant_cyc + 2)
        check("strobe_one_cycle", int'(mem_read_a | mem_write_a), 0);
      if (resp_valid_a != 4'b0) begin
        check("resp_onehot", $countones(resp_valid_a), 1);
        check("resp_latency", cyc - grant_cyc, 3);
        if (exp_resp.size() == 0) check("unexpected_resp", oh2i(resp_valid_a), -1);
        else begin
          resp_t r;
          r = exp_resp.pop_front();
          check("resp_idx", oh2i(resp_valid_a), r.idx);
          check("resp_rdata", int'(resp_rdata_a), r.rd);
        end
      end else if (resp_rdata_a != 8'h0) begin
        check("rdata_zero_when_idle", int'(resp_rdata_a), 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_grant_a(output int idx);
    idx = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready_a != 4'b0) begin
        idx = oh2i(req_ready_a);
        return;
      end
    end
    check("grant_timeout", 1, 0);
  endtask

  task automatic issue(int i, int w, int a, int d, int exp_rd, bit push_resp);
    int g;
    exp_grant.push_back('{i, w, a, d});
    if (push_resp) exp_resp.push_back('{i, exp_rd});
    ra[i] = 8'(a); rdw[i] = 8'(d); rw[i] = (w != 0); rv[i] = 1'b1;
    wait_grant_a(g);
    @(posedge clk); #1;
    rv[i] = 1'b0; rw[i] = 1'b0;
  endtask

  task automatic held(logic [3:0] mask, int n, bit drop, bit gap_chk);
    int g, last;
    last = -1;
    rv = rv | mask;
    for (int k = 0; k < n; k++) begin
      wait_grant_a(g);
      if (g < 0) break;
      if (gap_chk && last >= 0) check("grant_gap", cyc - last, 4);
      last = cyc;
      @(posedge clk); #1;
      if (drop) rv[g] = 1'b0;
    end
    rv = 4'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (exp_grant.size() == 0 && exp_resp.size() == 0) break;
    end
    check("drain_grants", exp_grant.size(), 0);
    check("drain_resps", exp_resp.size(), 0);
    exp_grant.delete();
    exp_resp.delete();
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_req_ready"},  int'(req_ready_a), 0);
    check({tag, "_resp_valid"}, int'(resp_valid_a), 0);
    check({tag, "_resp_rdata"}, int'(resp_rdata_a), 0);
    check({tag, "_mem_strobes"}, int'({mem_read_a, mem_write_a}), 0);
    check({tag, "_mem_addr"},   int'(mem_addr_a), 0);
    check({tag, "_mem_wdata"},  int'(mem_wdata_a), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int g, t;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'(i) ^ 8'hC3;
      mem_b[i] = 8'(i) ^ 8'hC3;
    end
    reset = 1'b0;
    rv = 4'b0; rw = 4'b0; rv_b = 4'b0; req_addr_b = 32'h0;
    for (int i = 0; i < 4; i++) begin ra[i] = 8'h0; rdw[i] = 8'h0; end
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // store then load back through requester 0
    issue(0, 1, 8'h10, 8'h5A, 0, 1'b1);
    drain();
    issue(0, 0, 8'h10, 8'h00, 8'h5A, 1'b1);
    drain();

    // all four hold loads from a fresh reset: grants 0,1,2,3, four cycles apart
    reset = 1'b0; @(posedge clk); #1; reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ra[i] = 8'h20 + 8'(i); rdw[i] = 8'h0; rw[i] = 1'b0;
      exp_grant.push_back('{i, 0, 8'h20 + i, 0});
    end
    exp_resp.push_back('{0, 8'hE3});
    exp_resp.push_back('{1, 8'hE2});
    exp_resp.push_back('{2, 8'hE1});
    exp_resp.push_back('{3, 8'hE0});
    held(4'b1111, 4, 1'b1, 1'b1);
    drain();

    // req0 and req2 held continuously: they must alternate
    ra[0] = 8'h50; ra[2] = 8'h52;
    exp_grant.push_back('{0, 0, 8'h50, 0});
    exp_grant.push_back('{2, 0, 8'h52, 0});
    exp_grant.push_back('{0, 0, 8'h50, 0});
    exp_grant.push_back('{2, 0, 8'h52, 0});
    exp_resp.push_back('{0, 8'h93});
    exp_resp.push_back('{2, 8'h91});
    exp_resp.push_back('{0, 8'h93});
    exp_resp.push_back('{2, 8'h91});
    held(4'b0101, 4, 1'b0, 1'b0);
    drain();

    // reset lands in WAIT: transaction dropped, rr_ptr back to 0
    issue(1, 0, 8'h41, 8'h00, 0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    check_all_zero("midreset_hold");
    reset = 1'b1;
    ra[1] = 8'h41; ra[3] = 8'h43;
    exp_grant.push_back('{1, 0, 8'h41, 0});
    exp_grant.push_back('{3, 0, 8'h43, 0});
    exp_resp.push_back('{1, 8'h82});
    exp_resp.push_back('{3, 8'h80});
    held(4'b1010, 2, 1'b1, 1'b0);
    drain();

    // LATENCY = 3 instance: resp five cycles after grant
    req_addr_b = {8'h33, 24'h0};
    rv_b = 4'b1000;
    t = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready_b != 4'b0) begin t = cyc; break; end
    end
    check("lat3_grant", int'(req_ready_b), 8);
    @(posedge clk); #1;
    rv_b = 4'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("lat3_resp_valid", int'(resp_valid_b), (k == 5) ? 8 : 0);
      check("lat3_resp_rdata", int'(resp_rdata_b), (k == 5) ? 8'hF0 : 0);
      check("lat3_mem_read", int'(mem_read_b), (k == 1) ? 1 : 0);
      if (k == 1) check("lat3_mem_addr", int'(mem_addr_b), 8'h33);
    end
    g = t;

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
